// File: rtl/ctrl_janela_bcd.sv
// ctrl_janela_bcd
// Gate-time controller for a 4-digit BCD pulse counter. Each measurement
// clears the counter (limp), opens a counting window of GATE_CICLOS clocks
// (hab), waits SETTLE_CICLOS clocks for the counter to settle, then captures
// cont_* into the display registers disp_* and pulses pronto.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   inicia, parar        start request (idle only) / abort (highest priority)
//   continuo             1: restart after each capture, 0: return to idle
//   cont_3..cont_0       BCD digits from the counter
//   limp, hab            counter clear / counter enable
//   disp_3..disp_0       captured digits, held between captures
//   pronto               one-cycle pulse with each new capture
//   ocupado              high whenever not idle
//   medidas              completed-capture count, wraps 255 -> 0
module ctrl_janela_bcd #(
  parameter int unsigned GATE_CICLOS   = 50_000_000,
  parameter int unsigned LIMP_CICLOS   = 2,
  parameter int unsigned SETTLE_CICLOS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicia,
  input  logic       parar,
  input  logic       continuo,
  input  logic [3:0] cont_3,
  input  logic [3:0] cont_2,
  input  logic [3:0] cont_1,
  input  logic [3:0] cont_0,
  output logic       limp,
  output logic       hab,
  output logic [3:0] disp_3,
  output logic [3:0] disp_2,
  output logic [3:0] disp_1,
  output logic [3:0] disp_0,
  output logic       pronto,
  output logic       ocupado,
  output logic [7:0] medidas
);

  localparam int unsigned MAX_LG = (GATE_CICLOS > LIMP_CICLOS) ? GATE_CICLOS : LIMP_CICLOS;
  localparam int unsigned MAX_P  = (MAX_LG > SETTLE_CICLOS) ? MAX_LG : SETTLE_CICLOS;
  localparam int unsigned TW     = $clog2(MAX_P + 1);

  localparam logic [TW-1:0] T_LIMP   = TW'(LIMP_CICLOS);
  localparam logic [TW-1:0] T_GATE   = TW'(GATE_CICLOS);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CICLOS);
  localparam logic [TW-1:0] T_UM     = TW'(1);

  typedef enum logic [2:0] {
    OCIOSO,
    LIMPA,
    CONTA,
    ESPERA,
    CAPTURA
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          limp_q, limp_d;
  logic          hab_q, hab_d;
  logic          pronto_q, pronto_d;
  logic          ocupado_q, ocupado_d;
  logic [15:0]   disp_q, disp_d;
  logic [7:0]    medidas_q, medidas_d;

  always_comb begin
    estado_d  = estado_q;
    tmr_d     = tmr_q;
    disp_d    = disp_q;
    medidas_d = medidas_q;
    pronto_d  = 1'b0;

    if (parar) begin
      estado_d = OCIOSO;
      tmr_d    = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (inicia) begin
            estado_d = LIMPA;
            tmr_d    = T_LIMP;
          end
        end
        LIMPA: begin
          if (tmr_q == T_UM) begin
            estado_d = CONTA;
            tmr_d    = T_GATE;
          end else begin
            tmr_d = tmr_q - T_UM;
          end
        end
        CONTA: begin
          if (tmr_q == T_UM) begin
            estado_d = ESPERA;
            tmr_d    = T_SETTLE;
          end else begin
            tmr_d = tmr_q - T_UM;
          end
        end
        ESPERA: begin
          if (tmr_q == T_UM) begin
            estado_d = CAPTURA;
            tmr_d    = T_UM;
          end else begin
            tmr_d = tmr_q - T_UM;
          end
        end
        CAPTURA: begin
          // Counter has been frozen for SETTLE_CICLOS, so cont_* is stable here.
          disp_d    = {cont_3, cont_2, cont_1, cont_0};
          medidas_d = medidas_q + 8'd1;
          pronto_d  = 1'b1;
          if (continuo) begin
            estado_d = LIMPA;
            tmr_d    = T_LIMP;
          end else begin
            estado_d = OCIOSO;
            tmr_d    = '0;
          end
        end
        default: begin
          estado_d = OCIOSO;
          tmr_d    = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    limp_d    = (estado_d == LIMPA);
    hab_d     = (estado_d == CONTA);
    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      tmr_q     <= '0;
      limp_q    <= 1'b0;
      hab_q     <= 1'b0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
      disp_q    <= '0;
      medidas_q <= '0;
    end else begin
      estado_q  <= estado_d;
      tmr_q     <= tmr_d;
      limp_q    <= limp_d;
      hab_q     <= hab_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
      disp_q    <= disp_d;
      medidas_q <= medidas_d;
    end
  end

  assign limp    = limp_q;
  assign hab     = hab_q;
  assign pronto  = pronto_q;
  assign ocupado = ocupado_q;
  assign disp_3  = disp_q[15:12];
  assign disp_2  = disp_q[11:8];
  assign disp_1  = disp_q[7:4];
  assign disp_0  = disp_q[3:0];
  assign medidas = medidas_q;

endmodule

// File: tb/tb_ctrl_janela_bcd.sv
// Testbench for ctrl_janela_bcd with G=10, L=2, S=3. A reference model tracks
// the position inside a measurement as a phase index and predicts every
// output each cycle.
module tb_ctrl_janela_bcd;

  localparam int L = 2;
  localparam int G = 10;
  localparam int S = 3;
  localparam int T = L + G + S + 1;

  logic       clk = 1'b0;
  logic       reset, inicia, parar, continuo;
  logic [3:0] cont_3, cont_2, cont_1, cont_0;
  logic       limp, hab, pronto, ocupado;
  logic [3:0] disp_3, disp_2, disp_1, disp_0;
  logic [7:0] medidas;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  bit          m_act;
  int          m_k;
  logic [15:0] m_disp;
  logic [7:0]  m_med;
  logic        m_pronto;

  ctrl_janela_bcd #(
    .GATE_CICLOS(G),
    .LIMP_CICLOS(L),
    .SETTLE_CICLOS(S)
  ) dut (
    .clk(clk), .reset(reset), .inicia(inicia), .parar(parar), .continuo(continuo),
    .cont_3(cont_3), .cont_2(cont_2), .cont_1(cont_1), .cont_0(cont_0),
    .limp(limp), .hab(hab),
    .disp_3(disp_3), .disp_2(disp_2), .disp_1(disp_1), .disp_0(disp_0),
    .pronto(pronto), .ocupado(ocupado), .medidas(medidas)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] obs_vec();
    return {limp, hab, pronto, ocupado, disp_3, disp_2, disp_1, disp_0, medidas};
  endfunction

  function automatic logic [27:0] exp_vec();
    logic el, eh;
    el = m_act && (m_k <= L);
    eh = m_act && (m_k > L) && (m_k <= L + G);
    return {el, eh, m_pronto, logic'(m_act), m_disp, m_med};
  endfunction

  // Advance one clock; the model samples the same inputs the DUT sees.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_act = 0; m_k = 0; m_disp = '0; m_med = '0; m_pronto = 1'b0;
    end else begin
      m_pronto = 1'b0;
      if (parar) m_act = 0;
      else if (!m_act) begin
        if (inicia) begin m_act = 1; m_k = 1; end
      end else if (m_k == T) begin
        m_disp   = {cont_3, cont_2, cont_1, cont_0};
        m_med    = m_med + 8'd1;
        m_pronto = 1'b1;
        if (continuo) m_k = 1;
        else m_act = 0;
      end else m_k++;
    end
    #1;
  endtask

  task automatic rand_cont();
    {cont_3, cont_2, cont_1, cont_0} = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; inicia = 1'b1; parar = 1'b0; continuo = 1'b0;
    for (int t = 0; t < 2; t++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
      n_checks++;
      if (obs_vec() !== 28'h0) begin
        n_err++; $display("FAIL reset_zero got=%h exp=0", obs_vec());
      end
    end
    reset = 1'b0; inicia = 1'b0;
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    int nl = 0, nh = 0, pat = 0;
    {cont_3, cont_2, cont_1, cont_0} = 16'h4321;
    continuo = 1'b0; inicia = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      tick();
      inicia = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL single cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
      nl += int'(limp); nh += int'(hab);
      if (pronto) pat = t;
    end
    n_checks++;
    if (pat != 17 || nl != 2 || nh != 10) begin
      n_err++; $display("FAIL single_timing pronto_at=%0d limp=%0d hab=%0d exp 17/2/10", pat, nl, nh);
    end
    n_checks++;
    if ({disp_3, disp_2, disp_1, disp_0} !== 16'h4321 || medidas !== 8'd1 || ocupado !== 1'b0) begin
      n_err++; $display("FAIL single_result disp=%h med=%0d ocup=%b exp 4321/1/0",
                        {disp_3, disp_2, disp_1, disp_0}, medidas, ocupado);
    end
  endtask

  task automatic test_continuous();
    int pt[$];
    logic [7:0] med0;
    med0 = medidas;
    continuo = 1'b1; inicia = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      inicia = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL continuous cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
      if (pronto) pt.push_back(t);
      rand_cont();
      if (t == 40) continuo = 1'b0;
    end
    n_checks++;
    if (pt.size() != 3 || pt[0] != 17 || pt[1] != 33 || pt[2] != 49) begin
      n_err++; $display("FAIL continuous_period prontos=%0d exp 3 at 17,33,49", pt.size());
    end
    n_checks++;
    if (medidas !== med0 + 8'd3) begin
      n_err++; $display("FAIL continuous_count got=%0d exp=%0d", medidas, med0 + 8'd3);
    end
  endtask

  task automatic test_parar();
    logic [15:0] d0;
    logic [7:0]  md0;
    int np = 0;
    d0 = {disp_3, disp_2, disp_1, disp_0}; md0 = medidas;
    continuo = 1'b0; inicia = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      tick();
      inicia = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL parar cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
      if (t == 8) begin
        n_checks++;
        if (hab !== 1'b0 || ocupado !== 1'b0) begin
          n_err++; $display("FAIL parar_stop hab=%b ocup=%b exp 0/0", hab, ocupado);
        end
      end
      np += int'(pronto);
      rand_cont();
      parar = (t == 7);
    end
    n_checks++;
    if (np != 0 || {disp_3, disp_2, disp_1, disp_0} !== d0 || medidas !== md0) begin
      n_err++; $display("FAIL parar_hold pronto=%0d disp=%h med=%0d exp 0/%h/%0d",
                        np, {disp_3, disp_2, disp_1, disp_0}, medidas, d0, md0);
    end
  endtask

  task automatic test_reset_mid();
    continuo = 1'b0; inicia = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      inicia = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
      if (t == 15) begin
        n_checks++;
        if (obs_vec() !== 28'h0) begin
          n_err++; $display("FAIL reset_mid_zero got=%h exp=0", obs_vec());
        end
      end
      if (t == 14 || t == 15) begin reset = 1'b1; inicia = 1'b1; end
      else reset = 1'b0;
    end
    n_checks++;
    if (ocupado !== 1'b0 || medidas !== 8'd0) begin
      n_err++; $display("FAIL reset_mid_idle ocup=%b med=%0d exp 0/0", ocupado, medidas);
    end
  endtask

  task automatic test_ignored();
    int nh = 0, np = 0;
    continuo = 1'b0; inicia = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ignored cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
      nh += int'(hab); np += int'(pronto);
      inicia = (t >= 3 && t <= 11) ? ((t == 6) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
    end
    n_checks++;
    if (nh != 10 || np != 1) begin
      n_err++; $display("FAIL ignored_window hab=%0d pronto=%0d exp 10/1", nh, np);
    end
    inicia = 1'b1; parar = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL both cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
      if (t == 2) begin inicia = 1'b0; parar = 1'b0; end
    end
    n_checks++;
    if (ocupado !== 1'b0) begin
      n_err++; $display("FAIL both_idle ocup=%b exp 0", ocupado);
    end
  endtask

  task automatic test_wrap();
    int np = 0;
    bit saw255 = 0;
    logic [7:0] med_last = 8'hxx;
    reset = 1'b1;
    tick();
    reset = 1'b0; continuo = 1'b1; inicia = 1'b1;
    for (int t = 1; t <= 4110; t++) begin
      tick();
      inicia = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL wrap cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
      if (medidas == 8'd255) saw255 = 1;
      if (pronto) begin np++; med_last = medidas; end
      rand_cont();
      if (t == 4090) continuo = 1'b0;
    end
    n_checks++;
    if (np != 256 || !saw255 || med_last !== 8'd0 || ocupado !== 1'b0) begin
      n_err++; $display("FAIL wrap_result prontos=%0d saw255=%0d last_med=%0d ocup=%b exp 256/1/0/0",
                        np, saw255, med_last, ocupado);
    end
  endtask

  initial begin
    reset = 1'b1; inicia = 1'b0; parar = 1'b0; continuo = 1'b0;
    {cont_3, cont_2, cont_1, cont_0} = 16'h0;
    m_act = 0; m_k = 0; m_disp = '0; m_med = '0; m_pronto = 1'b0;
    test_reset();
    test_single();
    test_continuous();
    test_parar();
    test_reset_mid();
    test_ignored();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_janela_bcd.md
# ctrl_janela_bcd

Gate-time controller that sequences the 4-digit BCD pulse counter (`limp`/`hab` inputs, `cont_3..cont_0` outputs) into repeatable frequency measurements. For each measurement it clears the counter, opens a counting window of exactly `GATE_CICLOS` system clocks, waits for the counter to settle, then captures the four digits into stable display registers and pulses `pronto`. It runs in single-shot or continuous mode and sits between the system clock domain and the counter / 7-segment display path.

## Interface
- `GATE_CICLOS`, default 50_000_000: length of the counting window in `clk` cycles, ≥1. The default is 1 s at 50 MHz.
- `LIMP_CICLOS`, default 2: cycles `limp` is held high before each window, ≥1.
- `SETTLE_CICLOS`, default 4: cycles between `hab` falling and capture, ≥1. Covers counter ripple and `clk_amostra` crossing.
- `clk`  in  1  system clock; everything samples on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inicia`  in  1  start request; sampled only in `OCIOSO`.
- `parar`  in  1  abort; takes priority over every other input in every state.
- `continuo`  in  1  at the end of `CAPTURA`: 1 starts a new measurement, 0 returns to idle.
- `cont_3`, `cont_2`, `cont_1`, `cont_0`  in  4 each  BCD digits from the counter.
- `limp`  out  1  counter clear, high during `LIMPA`.
- `hab`  out  1  counter enable, high during `CONTA`.
- `disp_3`, `disp_2`, `disp_1`, `disp_0`  out  4 each  captured digits, held between captures.
- `pronto`  out  1  one-cycle pulse when new `disp_*` values appear.
- `ocupado`  out  1  high whenever the state is not `OCIOSO`.
- `medidas`  out  8  count of completed captures; wraps 255→0.

## Operation
- FSM states: `OCIOSO`, `LIMPA`, `CONTA`, `ESPERA`, `CAPTURA`. A single down-counter `tmr` has width `$clog2(max parameter + 1)`. It is loaded on each state entry and the state exits when `tmr` reaches 1.
- `OCIOSO`: if `inicia=1` and `parar=0`, go to `LIMPA`.
- `LIMPA`: lasts `LIMP_CICLOS` cycles, then go to `CONTA`.
- `CONTA`: lasts `GATE_CICLOS` cycles, then go to `ESPERA`.
- `ESPERA`: lasts `SETTLE_CICLOS` cycles, then go to `CAPTURA`.
- `CAPTURA`: lasts 1 cycle. It loads `disp_* <= cont_*`, increments `medidas` and sets `pronto` for the next cycle. Next state is `LIMPA` if `continuo=1`, else `OCIOSO`.
- `parar=1` in any state: go to `OCIOSO` on the next edge.
  - `limp`, `hab` and `ocupado` read 0 from that edge.
  - If this happens in `CAPTURA`, there is no capture, no `pronto` and no `medidas` increment.
  - `disp_*` keep their previous values.
- `inicia` outside `OCIOSO` is ignored. `inicia` and `parar` high together in `OCIOSO`: stay in `OCIOSO`.
- `cont_*` are sampled only in `CAPTURA`, when the counter is frozen (`hab=0` for ≥`SETTLE_CICLOS`). No synchroniser is applied to them. Digit values >9 are passed through unchanged.
- Reset, including mid-measurement, takes effect on the next edge:
  - state `OCIOSO`, `tmr`=0;
  - `limp`, `hab`, `pronto`, `ocupado` = 0;
  - `disp_*` = 0, `medidas` = 0.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- `inicia` is sampled high at edge N:
  - `limp=1` for cycles N+1 .. N+L;
  - `hab=1` for cycles N+L+1 .. N+L+G (exactly G cycles);
  - `CAPTURA` is cycle N+L+G+S+1;
  - `pronto=1` and the new `disp_*` appear in cycle N+L+G+S+2.
  - Here L, G, S are `LIMP_CICLOS`, `GATE_CICLOS`, `SETTLE_CICLOS`.
- `limp` and `hab` are never high in the same cycle. There is no gap between the end of `limp` and the start of `hab`.
- Continuous mode period is L+G+S+1 cycles. `limp` rises in the same cycle `pronto` is high.
- `ocupado` rises the cycle after `inicia` is accepted and falls the cycle after leaving `CAPTURA` with `continuo=0`. In single-shot mode, `pronto` and the first `ocupado=0` cycle coincide.

## Test plan
Parameters: G=10, L=2, S=3; `cont_*` driven by a bench model.
- Reset held 2 cycles, then `inicia` pulsed once, `continuo=0`, model `cont_*`=4,3,2,1 → `limp` high 2 cycles, `hab` high exactly 10 cycles, `pronto` 1 cycle on the 17th cycle after `inicia`, `disp_*`=4,3,2,1, `medidas`=1, `ocupado`=0 afterwards.
- `continuo=1` for 3 measurements, `cont_*` changed between them → `pronto` every 16 cycles, `medidas`=3, each `disp_*` matches the value present in its `CAPTURA` cycle.
- `parar` during the 5th `hab` cycle → `hab`=0 next cycle, no `pronto`, `disp_*` and `medidas` unchanged, `ocupado`=0.
- `reset` asserted in `ESPERA` → next cycle all outputs 0, including `disp_*` and `medidas`; `inicia` while `reset=1` is ignored.
- `inicia` pulsed during `CONTA`; `inicia` and `parar` together in `OCIOSO` → no restart or extension of the window; controller remains idle in the second case.
- `medidas` preset to 255 by running 255 continuous measurements, then one more → wraps to 0 with `pronto` still issued.
